// File: rtl/gate_op_pkg.sv
// Shared definitions for the gate operation feeder: opcodes, FSM states, queued request layout.
package gate_op_pkg;

    // Gate opcodes; bit 1 drives chave1 (invert), bit 0 drives chave2 (OR vs AND)
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    // Issue FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        HOLD  = 2'b10
    } state_e;

    // One queued request as stored in the FIFO: {a, b, op}
    typedef struct packed {
        logic       a;
        logic       b;
        logic [1:0] op;
    } req_t;

endpackage

// File: rtl/gate_op_fifo.sv
// Small synchronous FIFO holding pending gate requests; reports its occupancy.
module gate_op_fifo
    import gate_op_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  req_t          wdata,
    input  logic          pop,
    output req_t          rdata,
    output logic [LW-1:0] level
);

    req_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    // Overflow/underflow are blocked here too so a misbehaving caller cannot corrupt the pointers
    assign do_push = push && (level_q != LW'(DEPTH));
    assign do_pop  = pop && (level_q != '0);

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/gate_op_feeder.sv
// Issue stage for the AND/OR/NAND/NOR gate unit: buffers requests, drives the gate
// from registers for one cycle, captures its result and hands it downstream.
module gate_op_feeder
    import gate_op_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_a,
    input  logic          in_b,
    input  logic [1:0]    in_op,
    output logic          gate_a,
    output logic          gate_b,
    output logic          gate_chave1,
    output logic          gate_chave2,
    input  logic          gate_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_result,
    output logic [1:0]    out_op,
    output logic [LW-1:0] level,
    output logic [7:0]    done_count
);

    state_e        state_q, state_d;
    logic          gate_a_q, gate_a_d;
    logic          gate_b_q, gate_b_d;
    logic          gate_c1_q, gate_c1_d;
    logic          gate_c2_q, gate_c2_d;
    logic [1:0]    op_q, op_d;
    logic          out_valid_q, out_valid_d;
    logic          out_result_q, out_result_d;
    logic [1:0]    out_op_q, out_op_d;
    logic [7:0]    done_count_q, done_count_d;

    logic          push, pop;
    req_t          in_req, head;
    logic [LW-1:0] fifo_level;

    // in_ready comes from the registered level, so a full FIFO never sees push+pop together
    assign in_ready = (fifo_level < LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign in_req   = '{a: in_a, b: in_b, op: in_op};

    gate_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_req),
        .pop   (pop),
        .rdata (head),
        .level (fifo_level)
    );

    assign level       = fifo_level;
    assign gate_a      = gate_a_q;
    assign gate_b      = gate_b_q;
    assign gate_chave1 = gate_c1_q;
    assign gate_chave2 = gate_c2_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_op      = out_op_q;
    assign done_count  = done_count_q;

    // Issue FSM next-state: pop into the drive registers, capture on DRIVE->HOLD, retire on handshake
    always_comb begin
        state_d      = state_q;
        gate_a_d     = gate_a_q;
        gate_b_d     = gate_b_q;
        gate_c1_d    = gate_c1_q;
        gate_c2_d    = gate_c2_q;
        op_d         = op_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        done_count_d = done_count_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                out_result_d = gate_result;
                out_op_d     = op_q;
                out_valid_d  = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d  = 1'b0;
                    done_count_d = done_count_q + 1'b1;
                    if (fifo_level != '0) begin
                        pop     = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Every pop loads the head entry into the gate drive registers
        if (pop) begin
            gate_a_d  = head.a;
            gate_b_d  = head.b;
            gate_c1_d = head.op[1];
            gate_c2_d = head.op[0];
            op_d      = head.op;
        end
    end

    // FSM, drive, capture and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            gate_c1_q    <= 1'b0;
            gate_c2_q    <= 1'b0;
            op_q         <= 2'b00;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_op_q     <= 2'b00;
            done_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            gate_a_q     <= gate_a_d;
            gate_b_q     <= gate_b_d;
            gate_c1_q    <= gate_c1_d;
            gate_c2_q    <= gate_c2_d;
            op_q         <= op_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            done_count_q <= done_count_d;
        end
    end

endmodule

// File: tb/tb_gate_op_feeder.sv
// Bench for gate_op_feeder: directed timing cases plus random traffic against a request scoreboard.
module tb_gate_op_feeder;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_a = 1'b0;
    logic          in_b = 1'b0;
    logic [1:0]    in_op = 2'b00;
    logic          gate_a, gate_b, gate_chave1, gate_chave2;
    logic          gate_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_result;
    logic [1:0]    out_op;
    logic [LW-1:0] level;
    logic [7:0]    done_count;

    gate_op_feeder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .gate_a      (gate_a),
        .gate_b      (gate_b),
        .gate_chave1 (gate_chave1),
        .gate_chave2 (gate_chave2),
        .gate_result (gate_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_op      (out_op),
        .level       (level),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    // Gate unit model: chave2 picks OR over AND, chave1 inverts
    assign gate_result = (gate_chave2 ? (gate_a | gate_b) : (gate_a & gate_b)) ^ gate_chave1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Opcode truth table
    function automatic logic ref_res(input logic a, input logic b, input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // Scoreboard: every accepted request must come back once, in order, with its result
    logic [3:0] q[$];
    logic       res_log[$];
    int         npush = 0;
    int         nhs = 0;
    logic [7:0] dmodel = 8'd0;
    logic       prev_hold = 1'b0;
    logic [7:0] snap;

    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst_n) begin
            q.delete();
            dmodel    = 8'd0;
            prev_hold = 1'b0;
        end else begin
            chk("done_count", 32'(done_count), 32'(dmodel));
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_stable", 32'({out_result, out_op, gate_a, gate_b, gate_chave1, gate_chave2}),
                    32'(snap[6:0]));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(out_result), 32'(ref_res(e[3], e[2], e[1:0])));
                    chk("result_op", 32'(out_op), 32'(e[1:0]));
                end
                res_log.push_back(out_result);
                dmodel = dmodel + 8'd1;
                nhs++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_a, in_b, in_op});
                npush++;
            end
            prev_hold = out_valid && !out_ready;
            snap = {1'b0, out_result, out_op, gate_a, gate_b, gate_chave1, gate_chave2};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive(input logic a, input logic b, input logic [1:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid || level != '0) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] lmax;
        int            p0, h0, n;

        // Reset state
        do_reset();
        chk("rst_outputs", 32'({out_valid, out_result, out_op, gate_a, gate_b, gate_chave1, gate_chave2}), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_done", 32'(done_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single request latency: accept at N, gate at N+1, out_valid at N+2
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 2'b00);
        tick();
        in_valid = 1'b0;
        chk("lat_level_n", 32'(level), 32'd1);
        chk("lat_valid_n", 32'(out_valid), 32'd0);
        tick();
        chk("lat_gate_n1", 32'({gate_a, gate_b, gate_chave1, gate_chave2}), 32'b1100);
        chk("lat_valid_n1", 32'(out_valid), 32'd0);
        chk("lat_level_n1", 32'(level), 32'd0);
        tick();
        chk("lat_valid_n2", 32'(out_valid), 32'd1);
        chk("lat_result", 32'({out_result, out_op}), 32'b100);
        tick();
        chk("lat_done", 32'(done_count), 32'd1);
        chk("lat_valid_clear", 32'(out_valid), 32'd0);

        // All four opcodes with a=1, b=0, pushed back to back
        do_reset();
        out_ready = 1'b1;
        res_log.delete();
        lmax = '0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'(i));
            tick();
            if (level > lmax) lmax = level;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (level > lmax) lmax = level;
        end
        drain("ops4_drain");
        chk("ops4_level_peak", 32'(lmax), 32'd2);
        chk("ops4_count", 32'(res_log.size()), 32'd4);
        if (res_log.size() == 4)
            chk("ops4_order", 32'({res_log[0], res_log[1], res_log[2], res_log[3]}), 32'b0110);
        chk("ops4_done", 32'(done_count), 32'd4);

        // Backpressure: five requests fill HOLD plus a full FIFO; a sixth is refused
        do_reset();
        res_log.delete();
        p0 = npush;
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 2'($urandom));
            tick();
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 1'b1, 2'b11);
        repeat (3) tick();
        chk("full_level_hold", 32'(level), 32'd4);
        chk("full_pushes", 32'(npush - p0), 32'd5);
        drain("full_drain");
        chk("full_done", 32'(done_count), 32'd5);
        chk("full_results", 32'(res_log.size()), 32'd5);

        // Push and pop in the same cycle at level 2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 2'(i + 1));
            tick();
        end
        in_valid = 1'b0;
        chk("pp_level_before", 32'(level), 32'd2);
        chk("pp_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 1'b1, 2'b10);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pp_level_after", 32'(level), 32'd2);
        drain("pp_drain");
        chk("pp_done", 32'(done_count), 32'd4);

        // Asynchronous reset while a request is in DRIVE with three more queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'b01);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_level", 32'(level), 32'd3);
        chk("mid_gate", 32'({gate_a, gate_b, gate_chave1, gate_chave2}), 32'b1101);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({out_valid, out_result, out_op, gate_a, gate_b, gate_chave1, gate_chave2}), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_done", 32'(done_count), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || level != '0) n++;
        end
        chk("mid_no_stale", 32'(n), 32'd0);

        // 256 completions wrap the counter back to 0
        do_reset();
        out_ready = 1'b1;
        p0 = npush;
        h0 = nhs;
        n = 0;
        while (((nhs - h0) < 256 || out_valid) && n < 3000) begin
            if ((npush - p0) < 256) drive(1'($urandom), 1'($urandom), 2'($urandom));
            else in_valid = 1'b0;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("wrap_handshakes", 32'(nhs - h0), 32'd256);
        chk("wrap_done", 32'(done_count), 32'd0);

        // Random traffic with random backpressure
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) != 0) drive(1'($urandom), 1'($urandom), 2'($urandom));
            else in_valid = 1'b0;
            out_ready = ($urandom_range(2) != 0);
            tick();
        end
        drain("rand_drain");
        chk("rand_done", 32'(done_count), 32'(dmodel));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_op_feeder.md
# gate_op_feeder

Upstream issue stage for the selectable AND/OR/NAND/NOR gate unit. It accepts operation requests (two operand bits plus a 2-bit operation code) over a valid/ready handshake and buffers them in a small FIFO. It drives the gate unit's `a`, `b`, `chave1`, `chave2` inputs one request at a time from registers, captures the gate's combinational `result`, and returns it downstream over a second valid/ready handshake. It also keeps a running count of completed operations.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: request present.
- `in_ready` output 1: FIFO can accept; equals `level < DEPTH`.
- `in_a`, `in_b` input 1 each: operand bits.
- `in_op` input 2: `[1]` maps to `chave1`, `[0]` maps to `chave2`.
- `gate_a`, `gate_b`, `gate_chave1`, `gate_chave2` output 1 each: registered drive to the gate unit.
- `gate_result` input 1: gate unit output, combinational from the `gate_*` signals.
- `out_valid` output 1: result held for downstream.
- `out_ready` input 1: downstream accepts.
- `out_result` output 1: captured gate result.
- `out_op` output 2: opcode that produced `out_result`.
- `level` output `$clog2(DEPTH)+1`: current FIFO occupancy.
- `done_count` output 8: completed handshakes; wraps 255→0.

## Operation
- Opcode encoding:
  - 00 = AND
  - 01 = OR
  - 10 = NAND
  - 11 = NOR
- Push: occurs when `in_valid & in_ready` is true at an edge.
- Pop: occurs on entry to DRIVE. The head entry loads into the `gate_*` registers, and its opcode loads into an internal `op_q`.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE → DRIVE when `level > 0` (pop). Otherwise stay in IDLE.
  - DRIVE → HOLD unconditionally. On this edge: `out_result ← gate_result`, `out_op ← op_q`, `out_valid ← 1`.
  - HOLD, with `out_valid & out_ready` true: `out_valid ← 0` and `done_count` increments. Then go to DRIVE (with a pop) if `level > 0`, else to IDLE.
  - HOLD, `out_ready` low: stay in HOLD. All outputs are held stable.
- Simultaneous push and pop: `level` is unchanged and the data order is preserved.
- Push into an empty FIFO while in IDLE: the entry is visible to the FSM on the next edge. There is no bypass.
- Full FIFO: `in_ready` is 0 and `in_valid` is ignored. A pop and a push in the same cycle while full is not possible, because `in_ready` is computed from the registered `level`.
- The `gate_*` registers keep their last values in IDLE and HOLD.
- Reset, asynchronous and applicable mid-operation, returns the block to IDLE and clears:
  - FIFO pointers and `level` → 0
  - all `gate_*` → 0
  - `out_valid`, `out_result`, `out_op`, `done_count` → 0
  - any in-flight request is discarded.

## Timing
- Request accepted at edge N:
  - `level` reflects it after edge N.
  - Pop occurs at edge N+1; `gate_*` are valid after N+1.
  - `out_valid` goes high after edge N+2.
  - Accept-to-result latency is therefore 2 cycles from an empty, idle block.
- Back-to-back throughput with `out_ready` tied high is one result every 2 cycles (HOLD → DRIVE → HOLD).
- `gate_*` are stable for the whole DRIVE cycle. The gate unit's combinational delay must fit within one cycle.
- `out_result` and `out_op` change only on the DRIVE → HOLD edge.

## Structure
- Package `gate_op_pkg`:
  - opcode localparams: `OP_AND=2'b00`, `OP_OR=2'b01`, `OP_NAND=2'b10`, `OP_NOR=2'b11`
  - state encoding constants for IDLE, DRIVE, HOLD.
- Sub-module `gate_op_fifo`: synchronous FIFO of `DEPTH` entries, 4-bit data `{a, b, op}`, with a level output and the same `clk`/`rst_n`.
- The FSM, drive registers, capture registers and counter stay in the top module.

## Test plan
- Reset, then push `a=1, b=1, op=00` and hold `out_ready=1` → `out_valid` rises 2 cycles after acceptance; `out_result=1`, `out_op=00`, `done_count=1`.
- Push four requests, one per op, all with `a=1, b=0` → results in order 0, 1, 1, 0; `level` peaks at the expected value; `done_count=4`.
- Hold `out_ready=0` and push 5 requests with `DEPTH=4` → one request is in HOLD, the FIFO fills to 4, and `in_ready=0` while the sixth `in_valid` is ignored; release `out_ready` → all 5 results drain in order.
- Assert `in_valid` and a pop in the same cycle with `level=2` → `level` stays 2 and the order is preserved.
- Assert `rst_n=0` mid-DRIVE with 3 entries queued → all outputs are immediately 0, the state is IDLE, `level=0`, and no stale result appears after reset release.
- Complete 256 operations → `done_count` wraps to 0.
